// File: rtl/writeback_regfile.sv
// WB stage and 32x32 integer register file: writeback mux, load extension, two read ports.
// Optional same-cycle write-through to the read ports when REGFILE_BYPASS_EN is defined.
module writeback_regfile #(
    parameter int unsigned XLEN               = 32,
    parameter int unsigned NREGS              = 32,
    parameter logic [XLEN-1:0] RESET_VALUE    = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] mem_data_read_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [4:0]      write_reg_i,
    input  logic [1:0]      mem_to_reg_i,
    input  logic            reg_write_i,
    input  logic [2:0]      load_funct3_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] wb_data_o
);

    logic [XLEN-1:0] regs [NREGS];
    logic [1:0]      off;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] wb_sel;
    logic            wr_en;

    assign off = alu_result_i[1:0];

    always_comb begin
        unique case (off)
            2'd0: load_byte = mem_data_read_i[7:0];
            2'd1: load_byte = mem_data_read_i[15:8];
            2'd2: load_byte = mem_data_read_i[23:16];
            2'd3: load_byte = mem_data_read_i[31:24];
        endcase
    end

    // Halfword loads use only off[1]; misaligned halves are not split.
    assign load_half = off[1] ? mem_data_read_i[31:16] : mem_data_read_i[15:0];

    always_comb begin
        case (load_funct3_i)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_ext = {24'd0, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b101:  load_ext = {16'd0, load_half};
            default: load_ext = mem_data_read_i;
        endcase
    end

    always_comb begin
        unique case (mem_to_reg_i)
            2'b01:   wb_sel = load_ext;
            2'b10:   wb_sel = pc_plus4_i;
            default: wb_sel = alu_result_i;
        endcase
    end

    assign wb_data_o = reset_i ? wb_sel : '0;
    assign wr_en     = reset_i && reg_write_i && (write_reg_i != 5'd0);

    always_ff @(posedge clk_i) begin
        regs[0] <= '0;
        if (!reset_i) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (wr_en) begin
            regs[write_reg_i] <= wb_sel;
        end
    end

    always_comb begin
        rs1_data_o = '0;
        rs2_data_o = '0;
        if (reset_i) begin
            rs1_data_o = regs[rs1_addr_i];
            rs2_data_o = regs[rs2_addr_i];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (write_reg_i == rs1_addr_i)) rs1_data_o = wb_sel;
            if (wr_en && (write_reg_i == rs2_addr_i)) rs2_data_o = wb_sel;
`endif
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: table-driven writeback/load vectors plus
// hand-written reset, x0, bypass and write-gating sequences.
module tb_writeback_regfile;

    logic        clk;
    logic        reset_i;
    logic [31:0] mem_data_read_i;
    logic [31:0] alu_result_i;
    logic [31:0] pc_plus4_i;
    logic [4:0]  write_reg_i;
    logic [1:0]  mem_to_reg_i;
    logic        reg_write_i;
    logic [2:0]  load_funct3_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] wb_data_o;

    int checks = 0;
    int errors = 0;

    writeback_regfile dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .mem_data_read_i (mem_data_read_i),
        .alu_result_i    (alu_result_i),
        .pc_plus4_i      (pc_plus4_i),
        .write_reg_i     (write_reg_i),
        .mem_to_reg_i    (mem_to_reg_i),
        .reg_write_i     (reg_write_i),
        .load_funct3_i   (load_funct3_i),
        .rs1_addr_i      (rs1_addr_i),
        .rs2_addr_i      (rs2_addr_i),
        .rs1_data_o      (rs1_data_o),
        .rs2_data_o      (rs2_data_o),
        .wb_data_o       (wb_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  m2r;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_alu(input logic [4:0] rd, input logic [31:0] val);
        mem_to_reg_i = 2'b00;
        alu_result_i = val;
        write_reg_i  = rd;
        reg_write_i  = 1'b1;
        tick();
        reg_write_i  = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 3'b010, 32'h0000_1234, 32'h0,         32'h0,     32'h0000_1234};
        vecs[1]  = '{2'b11, 3'b000, 32'hCAFE_F00D, 32'h0,         32'h0,     32'hCAFE_F00D};
        vecs[2]  = '{2'b10, 3'b000, 32'h0000_0055, 32'h0,         32'h104,   32'h0000_0104};
        vecs[3]  = '{2'b01, 3'b000, 32'h1000_0002, 32'h80FF_7F01, 32'h0,     32'hFFFF_FFFF};
        vecs[4]  = '{2'b01, 3'b100, 32'h1000_0003, 32'h80FF_7F01, 32'h0,     32'h0000_0080};
        vecs[5]  = '{2'b01, 3'b001, 32'h1000_0002, 32'h80FF_7F01, 32'h0,     32'hFFFF_80FF};
        vecs[6]  = '{2'b01, 3'b101, 32'h1000_0000, 32'h80FF_7F01, 32'h0,     32'h0000_7F01};
        vecs[7]  = '{2'b01, 3'b010, 32'h1000_0003, 32'h80FF_7F01, 32'h0,     32'h80FF_7F01};
        vecs[8]  = '{2'b01, 3'b011, 32'h1000_0001, 32'h80FF_7F01, 32'h0,     32'h80FF_7F01};
        vecs[9]  = '{2'b01, 3'b000, 32'h1000_0001, 32'h80FF_7F01, 32'h0,     32'h0000_007F};
        vecs[10] = '{2'b01, 3'b001, 32'h1000_0003, 32'h80FF_7F01, 32'h0,     32'hFFFF_80FF};
        vecs[11] = '{2'b01, 3'b101, 32'h1000_0001, 32'h80FF_7F01, 32'h0,     32'h0000_7F01};
        vecs[12] = '{2'b01, 3'b100, 32'h1000_0000, 32'h80FF_7F01, 32'h0,     32'h0000_0001};
        vecs[13] = '{2'b01, 3'b110, 32'h1000_0002, 32'h1234_5678, 32'h0,     32'h1234_5678};

        reset_i         = 1'b0;
        mem_data_read_i = 32'h0;
        alu_result_i    = 32'hFFFF_FFFF;
        pc_plus4_i      = 32'h0;
        write_reg_i     = 5'd0;
        mem_to_reg_i    = 2'b00;
        reg_write_i     = 1'b0;
        load_funct3_i   = 3'b010;
        rs1_addr_i      = 5'd5;
        rs2_addr_i      = 5'd31;
        tick();
        tick();
        check("reset_wb_forced_zero", wb_data_o, 32'h0);
        reset_i = 1'b1;
        #1;
        check("reset_rs1_x5", rs1_data_o, 32'h0);
        check("reset_rs2_x31", rs2_data_o, 32'h0);

        // Writeback mux and load extension vectors, each committed to x(i+1) and read back.
        for (int i = 0; i < 14; i++) begin
            mem_to_reg_i    = vecs[i].m2r;
            load_funct3_i   = vecs[i].f3;
            alu_result_i    = vecs[i].alu;
            mem_data_read_i = vecs[i].mem;
            pc_plus4_i      = vecs[i].pc4;
            write_reg_i     = 5'(i + 1);
            reg_write_i     = 1'b1;
            rs1_addr_i      = 5'd0;
            rs2_addr_i      = 5'd0;
            #1;
            check($sformatf("vec%0d_wb", i), wb_data_o, vecs[i].exp_wb);
            tick();
            reg_write_i = 1'b0;
            rs1_addr_i  = 5'(i + 1);
            rs2_addr_i  = 5'(i + 1);
            #1;
            check($sformatf("vec%0d_rs1", i), rs1_data_o, vecs[i].exp_wb);
            check($sformatf("vec%0d_rs2", i), rs2_data_o, vecs[i].exp_wb);
        end
        load_funct3_i = 3'b010;

        // Reset mid-stream: x5 written, then a pending write to x6 on the reset edge is lost.
        write_alu(5'd5, 32'hDEAD_BEEF);
        rs1_addr_i = 5'd5;
        #1;
        check("x5_before_reset", rs1_data_o, 32'hDEAD_BEEF);
        reset_i      = 1'b0;
        write_reg_i  = 5'd6;
        alu_result_i = 32'h0000_0055;
        reg_write_i  = 1'b1;
        #1;
        check("in_reset_rs1", rs1_data_o, 32'h0);
        check("in_reset_wb", wb_data_o, 32'h0);
        tick();
        reset_i     = 1'b1;
        reg_write_i = 1'b0;
        rs1_addr_i  = 5'd5;
        rs2_addr_i  = 5'd31;
        #1;
        check("post_reset_x5", rs1_data_o, 32'h0);
        check("post_reset_x31", rs2_data_o, 32'h0);
        rs1_addr_i = 5'd6;
        rs2_addr_i = 5'd1;
        #1;
        check("post_reset_x6_dropped", rs1_data_o, 32'h0);
        check("post_reset_x1", rs2_data_o, 32'h0);

        // x0 stays zero while being written every cycle.
        mem_to_reg_i = 2'b00;
        alu_result_i = 32'h1234_5678;
        write_reg_i  = 5'd0;
        reg_write_i  = 1'b1;
        rs1_addr_i   = 5'd0;
        rs2_addr_i   = 5'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("x0_rs1_c%0d", c), rs1_data_o, 32'h0);
            check($sformatf("x0_rs2_c%0d", c), rs2_data_o, 32'h0);
            tick();
        end
        reg_write_i = 1'b0;

        // Write-to-read on the same cycle: bypass depends on build.
        write_alu(5'd7, 32'h0000_0011);
        rs1_addr_i   = 5'd7;
        rs2_addr_i   = 5'd7;
        alu_result_i = 32'hA5A5_A5A5;
        write_reg_i  = 5'd7;
        reg_write_i  = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_rs1", rs1_data_o, 32'hA5A5_A5A5);
        check("bypass_same_rs2", rs2_data_o, 32'hA5A5_A5A5);
`else
        check("nobypass_same_rs1", rs1_data_o, 32'h0000_0011);
        check("nobypass_same_rs2", rs2_data_o, 32'h0000_0011);
`endif
        tick();
        reg_write_i = 1'b0;
        #1;
        check("bypass_next_rs1", rs1_data_o, 32'hA5A5_A5A5);
        check("bypass_next_rs2", rs2_data_o, 32'hA5A5_A5A5);

        // Write gating and back-to-back writes.
        write_alu(5'd9, 32'h0000_0033);
        alu_result_i = 32'h0000_0BAD;
        write_reg_i  = 5'd9;
        reg_write_i  = 1'b0;
        tick();
        rs1_addr_i = 5'd9;
        #1;
        check("gated_x9", rs1_data_o, 32'h0000_0033);
        reg_write_i  = 1'b1;
        alu_result_i = 32'h1;
        tick();
        alu_result_i = 32'h2;
        tick();
        reg_write_i = 1'b0;
        #1;
        check("b2b_x9", rs1_data_o, 32'h0000_0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
